// File: rtl/block_main_memory.sv
// Block-granular main memory behind the data cache: one block per access,
// fixed LATENCY-edge access time, combinational busywait handshake.
// Optional per-byte even parity on stored blocks: define MEM_PARITY_EN.
module block_main_memory #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned BLOCK_W = 32,
    parameter int unsigned LATENCY = 40
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               read,
    input  logic               write,
    input  logic [ADDR_W-1:0]  address,
    input  logic [BLOCK_W-1:0] writedata,
    output logic [BLOCK_W-1:0] readdata,
    output logic               busywait,
    output logic               parity_err
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int unsigned NBYTES = BLOCK_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] wdata_q;
    logic               op_write_q;
    logic [BLOCK_W-1:0] readdata_q;
    logic               parity_err_q;
    logic [BLOCK_W-1:0] mem_q [DEPTH];

    logic               accept_c;
    logic               complete_c;
    logic               busy_c;

    // State register and access counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    // Next-state, counter and handshake decode
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        accept_c   = 1'b0;
        complete_c = 1'b0;
        busy_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_c = read | write;
                if (read | write) begin
                    accept_c  = 1'b1;
                    counter_d = '0;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy_c    = 1'b1;
                counter_d = counter_q + CNT_W'(1);
                if (counter_q == CNT_W'(LATENCY - 1)) begin
                    complete_c = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request is held stable by the requester but latched anyway; write wins a dual request
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
        end else if (accept_c) begin
            addr_q     <= address;
            wdata_q    <= writedata;
            op_write_q <= write;
        end
    end

    // Block storage; reset clears every block
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (complete_c && op_write_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

`ifdef MEM_PARITY_EN
    logic [NBYTES-1:0] par_q [DEPTH];

    function automatic logic [NBYTES-1:0] calc_par(input logic [BLOCK_W-1:0] d);
        logic [NBYTES-1:0] p;
        for (int b = 0; b < int'(NBYTES); b++) begin
            p[b] = ^d[b*8 +: 8];
        end
        return p;
    endfunction

    // Parity storage written alongside the data block
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                par_q[i] <= '0;
            end
        end else if (complete_c && op_write_q) begin
            par_q[addr_q] <= calc_par(wdata_q);
        end
    end

    // Read result and recomputed-parity check; writes leave both untouched
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q   <= '0;
            parity_err_q <= 1'b0;
        end else if (complete_c && !op_write_q) begin
            readdata_q   <= mem_q[addr_q];
            parity_err_q <= (calc_par(mem_q[addr_q]) != par_q[addr_q]);
        end
    end
`else
    // Read result register; writes leave it untouched
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (complete_c && !op_write_q) begin
            readdata_q <= mem_q[addr_q];
        end
    end

    // No parity storage in this build
    always_ff @(posedge clock) begin
        parity_err_q <= 1'b0;
    end
`endif

    assign busywait   = busy_c & ~reset;
    assign readdata   = readdata_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_block_main_memory.sv
// Scoreboard bench for block_main_memory: the driver pushes the expected
// completion, a negedge monitor pops it when busywait falls.
// Define MEM_PARITY_EN for both files to exercise the parity path.
module tb_block_main_memory;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned BLOCK_W = 32;
    localparam int unsigned LATENCY = 40;

    logic               clock;
    logic               reset;
    logic               read;
    logic               write;
    logic [ADDR_W-1:0]  address;
    logic [BLOCK_W-1:0] writedata;
    logic [BLOCK_W-1:0] readdata;
    logic               busywait;
    logic               parity_err;

    block_main_memory #(
        .ADDR_W (ADDR_W),
        .BLOCK_W(BLOCK_W),
        .LATENCY(LATENCY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .busywait  (busywait),
        .parity_err(parity_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [BLOCK_W-1:0] rd;
        logic               pe;
        int                 cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on each busywait fall compare against the oldest expectation
    int busy_cnt  = 0;
    bit prev_busy = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busywait) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("readdata", readdata, e.rd);
                    check("parity_err", 32'(parity_err), 32'(e.pe));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.cyc));
                end
                busy_cnt = 0;
            end
            prev_busy = busywait;
        end
    end

    // Issue one request; inputs are scrambled after acceptance to prove latching
    task automatic do_op(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [BLOCK_W-1:0] d, input logic [BLOCK_W-1:0] exp_rd,
                         input logic exp_pe, input bit hold);
        int n;
        q.push_back('{exp_rd, exp_pe, int'(LATENCY) + 1});
        read      = rd;
        write     = wr;
        address   = a;
        writedata = d;
        #1;
        check("busy_in_request_cycle", 32'(busywait), 32'd1);
        @(posedge clock);
        #1;
        address   = ~a;
        writedata = ~d;
        n = 0;
        while (busywait && n < int'(LATENCY) + 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (busywait) begin
            check("completion_timeout", 32'd1, 32'd0);
        end
        if (hold) begin
            @(posedge clock);
            #1;
        end
        read  = 1'b0;
        write = 1'b0;
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                check("no_restart_after_hold", 32'(busywait), 32'd0);
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        read      = 1'b1;
        write     = 1'b0;
        address   = '0;
        writedata = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busywait_forced_low", 32'(busywait), 32'd0);
        check("reset_readdata", readdata, 32'h0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        read  = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;

        do_op(1'b1, 1'b0, 6'h05, 32'h0,        32'h0,        1'b0, 1'b0);
        do_op(1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
        do_op(1'b1, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
        do_op(1'b1, 1'b1, 6'h10, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 6'h10, 32'h0,        32'h12345678, 1'b0, 1'b0);

        // Write to 0x3F aborted by reset partway through the access
        address   = 6'h3F;
        writedata = 32'hCAFEF00D;
        write     = 1'b1;
        @(posedge clock);
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("busy_low_when_reset_asserted", 32'(busywait), 32'd0);
        repeat (2) begin
            @(posedge clock);
            #1;
            check("busy_low_during_reset", 32'(busywait), 32'd0);
        end
        write = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;

        do_op(1'b1, 1'b0, 6'h3F, 32'h0, 32'h0, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 6'h2A, 32'h0, 32'h0, 1'b0, 1'b0);

`ifdef MEM_PARITY_EN
        do_op(1'b0, 1'b1, 6'h01, 32'h000000FF, 32'h0, 1'b0, 1'b0);
        dut.mem_q[1] = 32'h000000FE;
        do_op(1'b1, 1'b0, 6'h01, 32'h0, 32'h000000FE, 1'b1, 1'b0);
        do_op(1'b1, 1'b0, 6'h02, 32'h0, 32'h0,        1'b0, 1'b0);
`endif

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
